// File: rtl/vram_writer.sv
// Framebuffer write side: buffers CPU pixel writes in a small FIFO and
// issues one registered write strobe per cycle, with a hardware clear-screen fill.
module vram_writer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [8:0]        req_x,
  input  logic [7:0]        req_y,
  input  logic [7:0]        req_color,
  input  logic              fill_start,
  input  logic [7:0]        fill_color,
  output logic              busy,
  output logic [7:0]        oob_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] H_A  = ADDR_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [PW:0]       FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, FILL} state_e;

  state_e              state_q;
  logic [ADDR_W+7:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0]       wp_q, rp_q;
  logic [PW:0]         cnt_q;
  logic                fill_pend_q;
  logic [7:0]          fill_color_q;
  logic [ADDR_W-1:0]   fill_cnt_q;
  logic [7:0]          oob_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;

  logic                empty, full, acc, in_rng, push, pop;
  logic [ADDR_W-1:0]   x_a, y_a, pix_addr;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL);
  assign req_ready = !full && !fill_pend_q && (state_q == IDLE);
  assign acc      = req_valid && req_ready;
  assign x_a      = ADDR_W'(req_x);
  assign y_a      = ADDR_W'(req_y);
  assign in_rng   = (x_a < W_A) && (y_a < H_A);
  assign pix_addr = y_a * W_A + x_a;
  assign push     = acc && in_rng;
  assign pop      = (state_q == IDLE) && !empty;

  assign busy      = !empty || fill_pend_q || (state_q == FILL) || mem_we_q;
  assign oob_cnt   = oob_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {pix_addr, req_color};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      fill_pend_q  <= 1'b0;
      fill_color_q <= '0;
      fill_cnt_q   <= '0;
      oob_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      // out-of-range requests complete the handshake but are only counted
      if (acc && !in_rng && oob_q != 8'hFF) oob_q <= oob_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (fill_start && !fill_pend_q) begin
            fill_pend_q  <= 1'b1;
            fill_color_q <= fill_color;
          end
          if (!empty) begin
            mem_we_q                  <= 1'b1;
            {mem_addr_q, mem_wdata_q} <= fifo_q[rp_q];
          end else if (fill_pend_q) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
          end
        end
        FILL: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= fill_cnt_q;
          mem_wdata_q <= fill_color_q;
          fill_cnt_q  <= fill_cnt_q + 1'b1;
          if (fill_cnt_q == LAST) begin
            state_q     <= IDLE;
            fill_pend_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: single writes, streaming, range drops,
// full-frame fill ordering, scoreboarded fill contention and reset mid-fill.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_x;
  logic [7:0]  req_y;
  logic [7:0]  req_color;
  logic        fill_start;
  logic [7:0]  fill_color;
  logic        busy;
  logic [7:0]  oob_cnt;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;

  int total  = 0;
  int passed = 0;

  vram_writer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .fill_start(fill_start), .fill_color(fill_color),
    .busy(busy), .oob_cnt(oob_cnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  logic [24:0] q[$];
  logic [24:0] e;

  initial begin
    int n, bad, rdy_bad, first_c, last_c, busy0_c, idx, fcnt, mism;
    bit done, we_seen, stop, a;

    rst = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0;
    req_color = '0; fill_start = 1'b0; fill_color = '0;
    tick(); tick();
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_oob",   32'(oob_cnt), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rdy",   32'(req_ready), 32'd1);
    rst = 1'b0;

    // single write, one-cycle latency
    req_valid = 1'b1; req_x = 9'd5; req_y = 8'd2; req_color = 8'hE0;
    tick();
    chk("t1_we_k", 32'(mem_we), 32'd0);
    req_valid = 1'b0;
    tick();
    chk("t1_we",    32'(mem_we), 32'd1);
    chk("t1_addr",  32'(mem_addr), 32'd645);
    chk("t1_wdata", 32'(mem_wdata), 32'hE0);
    tick();
    chk("t1_we_off", 32'(mem_we), 32'd0);
    chk("t1_busy",   32'(busy), 32'd0);

    // streaming writes keep order at one per cycle
    req_valid = 1'b1; req_y = 8'd0;
    for (int i = 0; i < 8; i++) begin
      req_x = 9'(i); req_color = 8'(i + 16);
      tick();
      if (i > 0) begin
        chk("t2_we",   32'(mem_we), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'(i - 1));
        chk("t2_rdy",  32'(req_ready), 32'd1);
      end
    end
    req_valid = 1'b0;
    tick();
    chk("t2_we7",   32'(mem_we), 32'd1);
    chk("t2_addr7", 32'(mem_addr), 32'd7);
    chk("t2_dat7",  32'(mem_wdata), 32'd23);
    tick();
    chk("t2_we_off", 32'(mem_we), 32'd0);

    // out-of-range drops and counter saturation
    req_valid = 1'b1; req_x = 9'd320; req_y = 8'd0;
    tick();
    chk("t3_we_a", 32'(mem_we), 32'd0);
    req_x = 9'd0; req_y = 8'd240;
    tick();
    chk("t3_we_b", 32'(mem_we), 32'd0);
    req_valid = 1'b0;
    tick();
    chk("t3_we_c", 32'(mem_we), 32'd0);
    chk("t3_oob2", 32'(oob_cnt), 32'd2);
    we_seen = 1'b0;
    req_valid = 1'b1; req_x = 9'd400; req_y = 8'd0;
    for (int i = 0; i < 300; i++) begin
      tick();
      we_seen |= mem_we;
    end
    req_valid = 1'b0;
    tick();
    chk("t3_oob_sat", 32'(oob_cnt), 32'd255);
    chk("t3_no_we",   32'(we_seen), 32'd0);

    // fill behind two queued requests
    req_valid = 1'b1; req_x = 9'd1; req_y = 8'd0; req_color = 8'h11;
    tick();
    req_x = 9'd2; req_color = 8'h22;
    fill_start = 1'b1; fill_color = 8'h1C;
    tick();
    req_valid = 1'b0; fill_start = 1'b0; fill_color = 8'h00;
    chk("t4_wa_we",   32'(mem_we), 32'd1);
    chk("t4_wa_addr", 32'(mem_addr), 32'd1);
    chk("t4_wa_dat",  32'(mem_wdata), 32'h11);
    chk("t4_rdy0",    32'(req_ready), 32'd0);
    tick();
    chk("t4_wb_we",   32'(mem_we), 32'd1);
    chk("t4_wb_addr", 32'(mem_addr), 32'd2);
    chk("t4_wb_dat",  32'(mem_wdata), 32'h22);
    n = 0; bad = 0; rdy_bad = 0; first_c = -1; last_c = -1;
    busy0_c = -1; done = 1'b0;
    for (int c = 0; c < 80000 && !done; c++) begin
      tick();
      if (mem_we) begin
        if (mem_addr != 17'(n) || mem_wdata != 8'h1C) bad++;
        if (first_c < 0) first_c = c;
        if (mem_addr == 17'd76799) last_c = c;
        else if (req_ready) rdy_bad++;
        n++;
      end
      if (!busy) begin
        done = 1'b1;
        busy0_c = c;
      end else if (!mem_we && req_ready) rdy_bad++;
    end
    chk("t4_done",   32'(done), 32'd1);
    chk("t4_count",  32'(n), 32'd76800);
    chk("t4_bad",    32'(bad), 32'd0);
    chk("t4_rdy",    32'(rdy_bad), 32'd0);
    chk("t4_contig", 32'(last_c - first_c), 32'd76799);
    chk("t4_busy",   32'(busy0_c), 32'(last_c + 1));
    chk("t4_rdy1",   32'(req_ready), 32'd1);

    // held requests racing a fill, scoreboarded, then reset mid-fill
    idx = 0; fcnt = 0; mism = 0; rdy_bad = 0; stop = 1'b0;
    req_valid = 1'b1; req_y = 8'd3; fill_color = 8'h55;
    for (int c = 0; c < 2000 && !stop; c++) begin
      fill_start = (c == 6);
      req_x = 9'(idx); req_color = 8'(8'h80 + idx);
      a = req_ready;
      if (a) q.push_back({17'(960 + idx), 8'(8'h80 + idx)});
      tick();
      fill_start = 1'b0;
      if (a) idx++;
      if (c >= 6 && req_ready) rdy_bad++;
      if (mem_we) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          if ({mem_addr, mem_wdata} != e) mism++;
        end else begin
          if (mem_addr != 17'(fcnt) || mem_wdata != 8'h55) mism++;
          fcnt++;
          if (mem_addr == 17'd1000) stop = 1'b1;
        end
      end
    end
    chk("t5_stop",    32'(stop), 32'd1);
    chk("t5_accepts", 32'(idx), 32'd7);
    chk("t5_q_empty", 32'(q.size()), 32'd0);
    chk("t5_mism",    32'(mism), 32'd0);
    chk("t5_rdy",     32'(rdy_bad), 32'd0);
    chk("t5_fcnt",    32'(fcnt), 32'd1001);

    rst = 1'b1; req_valid = 1'b0;
    tick();
    chk("t6_we",   32'(mem_we), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rdy",  32'(req_ready), 32'd1);
    chk("t6_oob",  32'(oob_cnt), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("t6_idle_we", 32'(mem_we), 32'd0);
    chk("t6_idle_bz", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
